round_sequencer: RTL and testbench
==================================

Name: round_sequencer

Overview:
- Frame-rate game-flow controller for the two-tank arena.
- Watches tank liveness and sequences the round through play, death animation, game-over/winner screen and respawn.
- Drives the pixel colour mapper's selection inputs (death-animation frame, which tank is dying, game-over overlay, winner id) and the round reset / movement freeze for the tank, bullet and wall logic.
- Keeps a per-player score and declares a match winner.

Parameters:
- FRAMES_PER_STEP, 5, frame_clk ticks each death-animation sprite is shown.
- ANIM_STEPS, 5, number of death sprites; animation indices run 0..ANIM_STEPS-1.
- GAMEOVER_HOLD, 60, minimum frames in GAMEOVER before restart_req is honoured.
- WIN_SCORE, 3, round wins needed to win the match (1..15).

Ports:
- frame_clk  in  1  frame-rate clock, one tick per video frame.
- Reset  in  1  asynchronous, active-high.
- tank1_alive  in  1  tank 1 alive status, level.
- tank2_alive  in  1  tank 2 alive status, level.
- restart_req  in  1  restart key, level; sampled on frame_clk.
- state  out  2  game_state_t: PLAY=0, DEATH=1, GAMEOVER=2, RESPAWN=3.
- dying1  out  1  tank 1 is shown with the death animation instead of its normal sprite.
- dying2  out  1  tank 2 is shown with the death animation instead of its normal sprite.
- anim_frame  out  3  death sprite index, 0..ANIM_STEPS-1.
- show_gameover  out  1  colour mapper draws the black background and game-over overlay.
- winner  out  2  round result: 00 none, 01 P1, 10 P2, 11 draw.
- freeze  out  1  tank and bullet motion inhibited.
- round_reset  out  1  one-frame pulse that reinitialises tanks, bullets and walls.
- score1  out  4  player 1 round wins.
- score2  out  4  player 2 round wins.
- match_over  out  1  a player has reached WIN_SCORE.

Behaviour:
- Reset (async): state=PLAY; all outputs 0; sub-counter and hold counter 0.
- All outputs are registered; a change takes effect on the frame_clk edge after the triggering input.
- PLAY:
  - freeze=0.
  - If tank1_alive=0 or tank2_alive=0 on an edge: go to DEATH, set dying1=~tank1_alive, dying2=~tank2_alive, anim_frame=0, sub=0.
  - Both tanks dead on the same edge: both dying flags set.
- DEATH:
  - freeze=1.
  - Each edge increments sub.
  - When sub=FRAMES_PER_STEP-1: sub wraps to 0 and anim_frame increments.
  - When anim_frame=ANIM_STEPS-1 and sub=FRAMES_PER_STEP-1: go to GAMEOVER.
  - DEATH lasts exactly FRAMES_PER_STEP*ANIM_STEPS frames (25 by default).
  - A tank that goes not-alive during DEATH sets its dying flag (sticky); the timer does not restart.
- GAMEOVER entry (the same edge):
  - winner = {dying1, dying2}, so 10 means P2 won and 01 means P1 won.
  - The surviving player's score increments, saturating at WIN_SCORE; a draw scores nobody.
  - match_over=1 if the new score equals WIN_SCORE.
  - show_gameover=1, hold=0, dying flags kept, anim_frame held at ANIM_STEPS-1.
- GAMEOVER:
  - freeze=1.
  - hold increments, saturating at GAMEOVER_HOLD.
  - restart_req=1 with hold=GAMEOVER_HOLD: go to RESPAWN, with round_reset=1 on that same edge.
  - restart_req while hold<GAMEOVER_HOLD is ignored and not queued.
- Leaving GAMEOVER:
  - Clears show_gameover, winner, dying1, dying2 and anim_frame.
  - If match_over was 1: score1, score2 and match_over are also cleared.
- RESPAWN:
  - freeze=1.
  - round_reset=1 for exactly the first frame in RESPAWN, then 0.
  - From the second frame on, tank1_alive=1 and tank2_alive=1 goes to PLAY.
  - Otherwise it waits indefinitely; there is no timeout.
- Liveness inputs are ignored in GAMEOVER and RESPAWN.
- Reset asserted mid-sequence, in any state, returns immediately to the reset values, including the scores.
- Counter widths: sub needs ceil(log2(FRAMES_PER_STEP)) bits and hold needs ceil(log2(GAMEOVER_HOLD+1)) bits.
- No arithmetic wraps: every counter either saturates or is explicitly reloaded.

Decomposition:
- tank_game_pkg holds:
  - the game_state_t enum;
  - WINNER_NONE/P1/P2/DRAW constants;
  - the default FRAMES_PER_STEP, ANIM_STEPS, GAMEOVER_HOLD and WIN_SCORE values, shared with the colour mapper.
- One sub-module, frame_counter: parameterised up-counter with clear, enable and a terminal-count output. Two instances, sub and hold.
- The FSM and score logic stay in round_sequencer.

Test Plan:
- Reset, then drop tank2_alive at frame 10:
  - frame 11: state=DEATH, dying2=1, anim_frame=0;
  - anim_frame steps every 5 frames;
  - frame 36: GAMEOVER, winner=01, score1=1, show_gameover=1.
- Drop both alive flags on the same edge: winner=11 after 25 frames, scores unchanged.
- Drop tank1_alive, then drop tank2_alive 7 frames into DEATH:
  - dying2 sets without restarting the timer;
  - GAMEOVER at 25 frames, winner=11.
- In GAMEOVER, pulse restart_req at hold=30: ignored. Hold it high at hold=60:
  - next edge: RESPAWN, round_reset=1 for 1 frame, show_gameover=0;
  - raise both alive flags: PLAY, freeze=0.
- P1 wins 3 rounds: score1=3 and match_over=1 on the third GAMEOVER entry; the next restart clears score1, score2 and match_over.
- Assert Reset mid-DEATH at anim_frame=2: all outputs 0 asynchronously; after release, state=PLAY.

Source files
------------

// File: rtl/tank_game_pkg.sv
// ============================================================================
// tank_game_pkg -- shared game-flow types and defaults for the tank arena
// Revision: 1.0
// ============================================================================
`default_nettype none

package tank_game_pkg;

  typedef enum logic [1:0] {
    PLAY     = 2'd0,
    DEATH    = 2'd1,
    GAMEOVER = 2'd2,
    RESPAWN  = 2'd3
  } game_state_t;

  // Winner code is {tank1 died, tank2 died}
  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;
  localparam logic [1:0] WINNER_DRAW = 2'b11;

  localparam int DEF_FRAMES_PER_STEP = 5;
  localparam int DEF_ANIM_STEPS      = 5;
  localparam int DEF_GAMEOVER_HOLD   = 60;
  localparam int DEF_WIN_SCORE       = 3;

  function automatic logic [3:0] sat_inc(input logic [3:0] value, input logic [3:0] limit);
    return (value >= limit) ? value : value + 4'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/frame_counter.sv
// ============================================================================
// frame_counter -- up-counter with clear, enable and terminal-count flag
// Revision: 1.0
// ============================================================================
`default_nettype none

module frame_counter #(
  parameter int WIDTH     = 3,
  parameter int MAX_COUNT = 4,
  parameter bit WRAP      = 1'b1
) (
  input  logic frame_clk,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic at_max
);

  localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] r_count;

  assign at_max = (r_count == c_MAX);

  // At the terminal value the counter either reloads zero or holds
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      if (at_max) begin
        r_count <= WRAP ? '0 : r_count;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/round_sequencer.sv
// ============================================================================
// round_sequencer -- frame-rate round flow, death animation and scoring
// Revision: 1.0
// ============================================================================
`default_nettype none

module round_sequencer
  import tank_game_pkg::*;
#(
  parameter int FRAMES_PER_STEP = DEF_FRAMES_PER_STEP,
  parameter int ANIM_STEPS      = DEF_ANIM_STEPS,
  parameter int GAMEOVER_HOLD   = DEF_GAMEOVER_HOLD,
  parameter int WIN_SCORE       = DEF_WIN_SCORE
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       tank1_alive,
  input  logic       tank2_alive,
  input  logic       restart_req,
  output logic [1:0] state,
  output logic       dying1,
  output logic       dying2,
  output logic [2:0] anim_frame,
  output logic       show_gameover,
  output logic [1:0] winner,
  output logic       freeze,
  output logic       round_reset,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic       match_over
);

  localparam int         c_SUB_W     = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int         c_HOLD_W    = (GAMEOVER_HOLD > 0) ? $clog2(GAMEOVER_HOLD + 1) : 1;
  localparam logic [2:0] c_ANIM_LAST = 3'(ANIM_STEPS - 1);
  localparam logic [3:0] c_WIN_SCORE = 4'(WIN_SCORE);

  game_state_t r_state, w_state_nxt;
  logic        r_dying1, r_dying2, r_show_gameover, r_freeze, r_round_reset, r_match_over;
  logic [2:0]  r_anim_frame;
  logic [1:0]  r_winner;
  logic [3:0]  r_score1, r_score2;

  logic        w_dying1_nxt, w_dying2_nxt, w_show_nxt, w_freeze_nxt, w_round_reset_nxt;
  logic        w_match_nxt;
  logic [2:0]  w_anim_nxt;
  logic [1:0]  w_winner_nxt;
  logic [3:0]  w_score1_nxt, w_score2_nxt;
  logic        w_sub_tc, w_hold_tc;

  frame_counter #(
    .WIDTH     (c_SUB_W),
    .MAX_COUNT (FRAMES_PER_STEP - 1),
    .WRAP      (1'b1)
  ) u_sub (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .clear     (r_state != DEATH),
    .enable    (r_state == DEATH),
    .at_max    (w_sub_tc)
  );

  frame_counter #(
    .WIDTH     (c_HOLD_W),
    .MAX_COUNT (GAMEOVER_HOLD),
    .WRAP      (1'b0)
  ) u_hold (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .clear     (r_state != GAMEOVER),
    .enable    (r_state == GAMEOVER),
    .at_max    (w_hold_tc)
  );

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state         <= PLAY;
      r_dying1        <= 1'b0;
      r_dying2        <= 1'b0;
      r_anim_frame    <= 3'd0;
      r_show_gameover <= 1'b0;
      r_winner        <= WINNER_NONE;
      r_freeze        <= 1'b0;
      r_round_reset   <= 1'b0;
      r_score1        <= 4'd0;
      r_score2        <= 4'd0;
      r_match_over    <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_dying1        <= w_dying1_nxt;
      r_dying2        <= w_dying2_nxt;
      r_anim_frame    <= w_anim_nxt;
      r_show_gameover <= w_show_nxt;
      r_winner        <= w_winner_nxt;
      r_freeze        <= w_freeze_nxt;
      r_round_reset   <= w_round_reset_nxt;
      r_score1        <= w_score1_nxt;
      r_score2        <= w_score2_nxt;
      r_match_over    <= w_match_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      PLAY:     if (!tank1_alive || !tank2_alive) w_state_nxt = DEATH;
      DEATH:    if (w_sub_tc && (r_anim_frame == c_ANIM_LAST)) w_state_nxt = GAMEOVER;
      GAMEOVER: if (restart_req && w_hold_tc) w_state_nxt = RESPAWN;
      // round_reset high marks the first respawn frame, which never exits
      RESPAWN:  if (!r_round_reset && tank1_alive && tank2_alive) w_state_nxt = PLAY;
      default:  w_state_nxt = PLAY;
    endcase
  end

  always_comb begin
    w_dying1_nxt      = r_dying1;
    w_dying2_nxt      = r_dying2;
    w_anim_nxt        = r_anim_frame;
    w_show_nxt        = r_show_gameover;
    w_winner_nxt      = r_winner;
    w_score1_nxt      = r_score1;
    w_score2_nxt      = r_score2;
    w_match_nxt       = r_match_over;
    w_round_reset_nxt = 1'b0;
    w_freeze_nxt      = (w_state_nxt != PLAY);

    case (r_state)
      PLAY: begin
        if (w_state_nxt == DEATH) begin
          w_dying1_nxt = ~tank1_alive;
          w_dying2_nxt = ~tank2_alive;
          w_anim_nxt   = 3'd0;
        end
      end
      DEATH: begin
        w_dying1_nxt = r_dying1 | ~tank1_alive;
        w_dying2_nxt = r_dying2 | ~tank2_alive;
        if (w_sub_tc && (r_anim_frame != c_ANIM_LAST)) begin
          w_anim_nxt = r_anim_frame + 3'd1;
        end
        if (w_state_nxt == GAMEOVER) begin
          w_winner_nxt = {w_dying1_nxt, w_dying2_nxt};
          w_show_nxt   = 1'b1;
          case (w_winner_nxt)
            WINNER_P1: begin
              w_score1_nxt = sat_inc(r_score1, c_WIN_SCORE);
              w_match_nxt  = (w_score1_nxt == c_WIN_SCORE);
            end
            WINNER_P2: begin
              w_score2_nxt = sat_inc(r_score2, c_WIN_SCORE);
              w_match_nxt  = (w_score2_nxt == c_WIN_SCORE);
            end
            WINNER_NONE, WINNER_DRAW: ;
            default: ;
          endcase
        end
      end
      GAMEOVER: begin
        if (w_state_nxt == RESPAWN) begin
          w_round_reset_nxt = 1'b1;
          w_show_nxt        = 1'b0;
          w_winner_nxt      = WINNER_NONE;
          w_dying1_nxt      = 1'b0;
          w_dying2_nxt      = 1'b0;
          w_anim_nxt        = 3'd0;
          if (r_match_over) begin
            w_score1_nxt = 4'd0;
            w_score2_nxt = 4'd0;
            w_match_nxt  = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  assign state         = r_state;
  assign dying1        = r_dying1;
  assign dying2        = r_dying2;
  assign anim_frame    = r_anim_frame;
  assign show_gameover = r_show_gameover;
  assign winner        = r_winner;
  assign freeze        = r_freeze;
  assign round_reset   = r_round_reset;
  assign score1        = r_score1;
  assign score2        = r_score2;
  assign match_over    = r_match_over;

endmodule

`default_nettype wire

// File: tb/tb_round_sequencer.sv
// ============================================================================
// tb_round_sequencer -- directed bench for the round flow and scoring
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_round_sequencer;

  logic       frame_clk = 1'b0;
  logic       Reset, tank1_alive, tank2_alive, restart_req;
  logic [1:0] state, winner;
  logic       dying1, dying2, show_gameover, freeze, round_reset, match_over;
  logic [2:0] anim_frame;
  logic [3:0] score1, score2;

  int n_pass  = 0;
  int n_total = 0;

  round_sequencer dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .tank1_alive   (tank1_alive),
    .tank2_alive   (tank2_alive),
    .restart_req   (restart_req),
    .state         (state),
    .dying1        (dying1),
    .dying2        (dying2),
    .anim_frame    (anim_frame),
    .show_gameover (show_gameover),
    .winner        (winner),
    .freeze        (freeze),
    .round_reset   (round_reset),
    .score1        (score1),
    .score2        (score2),
    .match_over    (match_over)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge frame_clk);
  endtask

  // Entered at the negedge right after GAMEOVER entry (hold = 0)
  task automatic restart_round();
    tick(60);
    restart_req = 1'b1;
    tick(1);
    restart_req = 1'b0;
    check("rs_state_respawn", state, 3);
    check("rs_round_reset", round_reset, 1);
    tank1_alive = 1'b1;
    tank2_alive = 1'b1;
    tick(2);
    check("rs_state_play", state, 0);
  endtask

  // Kill the given tanks for one edge, then run DEATH through to GAMEOVER
  task automatic death_round(input logic a1, input logic a2);
    tank1_alive = a1;
    tank2_alive = a2;
    tick(1);
    check("dr_enter_death", state, 1);
    tank1_alive = 1'b1;
    tank2_alive = 1'b1;
    tick(24);
    check("dr_still_death", state, 1);
    tick(1);
    check("dr_gameover", state, 2);
  endtask

  initial begin
    Reset       = 1'b1;
    tank1_alive = 1'b1;
    tank2_alive = 1'b1;
    restart_req = 1'b0;
    tick(2);
    check("rst_state", state, 0);
    check("rst_freeze", freeze, 0);
    check("rst_show", show_gameover, 0);
    check("rst_winner", winner, 0);
    check("rst_score1", score1, 0);
    check("rst_match", match_over, 0);
    check("rst_round_reset", round_reset, 0);
    Reset = 1'b0;
    tick(10);
    check("idle_play", state, 0);

    // P1 wins: tank 2 dies and stays down through respawn
    tank2_alive = 1'b0;
    tick(1);
    check("a_death", state, 1);
    check("a_dying2", dying2, 1);
    check("a_dying1", dying1, 0);
    check("a_anim0", anim_frame, 0);
    check("a_freeze", freeze, 1);
    tick(5);
    check("a_anim1", anim_frame, 1);
    tick(15);
    check("a_anim4", anim_frame, 4);
    tick(4);
    check("a_death_len", state, 1);
    tick(1);
    check("a_gameover", state, 2);
    check("a_winner", winner, 1);
    check("a_score1", score1, 1);
    check("a_score2", score2, 0);
    check("a_show", show_gameover, 1);
    check("a_anim_hold", anim_frame, 4);
    check("a_match", match_over, 0);
    tick(30);
    restart_req = 1'b1;
    tick(1);
    restart_req = 1'b0;
    check("a_early_restart", state, 2);
    check("a_go_freeze", freeze, 1);
    tick(29);
    restart_req = 1'b1;
    tick(1);
    restart_req = 1'b0;
    check("a_respawn", state, 3);
    check("a_round_reset1", round_reset, 1);
    check("a_show_clr", show_gameover, 0);
    check("a_winner_clr", winner, 0);
    check("a_dying_clr", dying2, 0);
    check("a_anim_clr", anim_frame, 0);
    check("a_score_kept", score1, 1);
    tick(1);
    check("a_round_reset0", round_reset, 0);
    tick(3);
    check("a_wait_respawn", state, 3);
    tank2_alive = 1'b1;
    tick(1);
    check("a_play", state, 0);
    check("a_unfreeze", freeze, 0);

    // Simultaneous deaths: draw
    death_round(1'b0, 1'b0);
    check("b_winner", winner, 3);
    check("b_dying1", dying1, 1);
    check("b_score1", score1, 1);
    check("b_score2", score2, 0);
    restart_round();

    // Tank 2 dies 7 frames into DEATH: sticky flag, timer not restarted
    tank1_alive = 1'b0;
    tick(1);
    check("c_dying1", dying1, 1);
    check("c_dying2_0", dying2, 0);
    tank1_alive = 1'b1;
    tick(7);
    tank2_alive = 1'b0;
    tick(1);
    check("c_dying2_1", dying2, 1);
    check("c_death", state, 1);
    tank2_alive = 1'b1;
    tick(16);
    check("c_no_restart", state, 1);
    tick(1);
    check("c_gameover", state, 2);
    check("c_winner", winner, 3);
    check("c_score1", score1, 1);
    restart_round();

    // Match: P1, P2, P1 -> P1 reaches 3
    death_round(1'b1, 1'b0);
    check("d_score1_2", score1, 2);
    check("d_match0", match_over, 0);
    restart_round();
    death_round(1'b0, 1'b1);
    check("d_winner_p2", winner, 2);
    check("d_score2_1", score2, 1);
    restart_round();
    death_round(1'b1, 1'b0);
    check("d_score1_3", score1, 3);
    check("d_match1", match_over, 1);
    restart_round();
    check("d_score1_clr", score1, 0);
    check("d_score2_clr", score2, 0);
    check("d_match_clr", match_over, 0);

    // Async reset mid-DEATH clears scores too
    death_round(1'b1, 1'b0);
    check("e_score1", score1, 1);
    restart_round();
    tank2_alive = 1'b0;
    tick(1);
    tank2_alive = 1'b1;
    tick(10);
    check("e_anim2", anim_frame, 2);
    #1 Reset = 1'b1;
    #1;
    check("e_state", state, 0);
    check("e_score1_clr", score1, 0);
    check("e_dying2", dying2, 0);
    check("e_freeze", freeze, 0);
    check("e_anim", anim_frame, 0);
    tick(2);
    Reset = 1'b0;
    tick(1);
    check("e_play", state, 0);
    check("e_unfreeze", freeze, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
